rat_io_responder: RTL

- Peripheral-side responder for the RAT CPU's IN/OUT port bus.
- Latches OUT writes into output registers (LEDs, seven-segment data, interrupt mask).
- Serves IN reads from synchronized switches, debounced buttons and interrupt status.
- Produces the INT request the control unit consumes, handshaking with its interrupt-accept pulse.

---
 rtl/rat_io_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rat_io_responder.sv
// rat_io_responder -- peripheral-side responder for the RAT CPU IN/OUT port bus.
//
// Latches OUT writes into LED, seven-segment and interrupt-mask registers,
// serves IN reads (synchronized switches, debounced buttons, interrupt
// status/mask, LED/SSEG readback) and drives the INT request to the control
// unit, handshaking with INT_ACK.
//
// Ports:
//   CLK        system clock, all state on rising edge
//   RESET_N    asynchronous active-low reset
//   PORT_ID    port address from CPU
//   OUT_PORT   write data from CPU
//   IO_STRB    one-cycle write strobe
//   IN_PORT    read data, combinational on PORT_ID
//   SWITCHES   asynchronous board switches
//   BUTTONS    asynchronous board buttons
//   INT_ACK    one-cycle interrupt-accept pulse
//   LEDS       LED register
//   SSEG_DATA  seven-segment data register
//   INT        registered interrupt request
//
// Optional feature: define RAT_IO_TIMER_EN to add an 8-bit reload timer at
// port 8'h31 that raises interrupt source 4.

module rat_io_responder #(
  parameter logic [7:0]  SW_ID     = 8'h20,
  parameter logic [7:0]  BTN_ID    = 8'hFF,
  parameter logic [7:0]  LED_ID    = 8'h40,
  parameter logic [7:0]  SSEG_ID   = 8'h81,
  parameter logic [7:0]  ISTAT_ID  = 8'h30,
  parameter logic [7:0]  IMASK_ID  = 8'h32,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  input  logic       INT_ACK,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_DATA,
  output logic       INT
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
`ifdef RAT_IO_TIMER_EN
  localparam int unsigned PW     = 5;
  localparam logic [7:0]  TMR_ID = 8'h31;
`else
  localparam int unsigned PW     = 4;
`endif

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_n;
  logic            int_q;
  logic [7:0]      sw_s1, sw_s2;
  logic [3:0]      btn_s1, btn_s2;
  logic [3:0]      db_lvl, db_lvl_n, btn_rise;
  logic [CW-1:0]   db_cnt   [4];
  logic [CW-1:0]   db_cnt_n [4];
  logic [PW-1:0]   pending, pending_n, mask, set_bits;
  logic            wr_led, wr_sseg, wr_mask, wr_istat;
  logic            req;

  assign wr_led   = IO_STRB && (PORT_ID == LED_ID);
  assign wr_sseg  = IO_STRB && (PORT_ID == SSEG_ID);
  assign wr_mask  = IO_STRB && (PORT_ID == IMASK_ID);
  assign wr_istat = IO_STRB && (PORT_ID == ISTAT_ID);

  // Debounce: count consecutive samples that disagree with the accepted level;
  // the DB_CYCLES-th disagreeing sample is accepted.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      db_lvl_n[i] = db_lvl[i];
      db_cnt_n[i] = '0;
      btn_rise[i] = 1'b0;
      if (btn_s2[i] != db_lvl[i]) begin
        if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          db_lvl_n[i] = btn_s2[i];
          btn_rise[i] = btn_s2[i];
        end else begin
          db_cnt_n[i] = db_cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef RAT_IO_TIMER_EN
  logic [7:0] tmr_reload, tmr_cnt;
  logic       wr_tmr, tmr_fire;

  assign wr_tmr   = IO_STRB && (PORT_ID == TMR_ID);
  assign tmr_fire = !wr_tmr && (tmr_reload != '0) && (tmr_cnt == '0);
  assign set_bits = {tmr_fire, btn_rise};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmr_reload <= '0;
      tmr_cnt    <= '0;
    end else if (wr_tmr) begin
      tmr_reload <= OUT_PORT;
      tmr_cnt    <= OUT_PORT;
    end else if (tmr_reload != '0) begin
      tmr_cnt <= (tmr_cnt == '0) ? tmr_reload : tmr_cnt - 8'd1;
    end
  end
`else
  assign set_bits = btn_rise;
`endif

  // New set edges override a same-cycle write-1-to-clear.
  assign pending_n = (pending & ~(wr_istat ? OUT_PORT[PW-1:0] : '0)) | set_bits;
  assign req       = |(pending & mask);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req)      state_n = REQ;
      REQ:     if (INT_ACK)  state_n = SERVICE;
      SERVICE: if (wr_istat) state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      int_q     <= 1'b0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      db_lvl    <= '0;
      pending   <= '0;
      mask      <= '0;
      LEDS      <= '0;
      SSEG_DATA <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      state   <= state_n;
      int_q   <= (state_n == REQ);
      sw_s1   <= SWITCHES;
      sw_s2   <= sw_s1;
      btn_s1  <= BUTTONS;
      btn_s2  <= btn_s1;
      db_lvl  <= db_lvl_n;
      pending <= pending_n;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= db_cnt_n[i];
      if (wr_led)  LEDS      <= OUT_PORT;
      if (wr_sseg) SSEG_DATA <= OUT_PORT;
      if (wr_mask) mask      <= OUT_PORT[PW-1:0];
    end
  end

  assign INT = int_q;

  always_comb begin
    IN_PORT = '0;
    case (PORT_ID)
      SW_ID:    IN_PORT = sw_s2;
      BTN_ID:   IN_PORT = 8'(db_lvl);
      ISTAT_ID: IN_PORT = 8'(pending);
      IMASK_ID: IN_PORT = 8'(mask);
      LED_ID:   IN_PORT = LEDS;
      SSEG_ID:  IN_PORT = SSEG_DATA;
`ifdef RAT_IO_TIMER_EN
      TMR_ID:   IN_PORT = tmr_reload;
`endif
      default:  IN_PORT = '0;
    endcase
  end

endmodule
